// File: rtl/de0clkgen.sv
// Multi-channel fractional clock-enable generator with PLL-lock reset sequencing.
// Channels accumulate only while the lock sequencer stays in RUN; writes are accepted at any time.
module de0clkgen #(
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 16,
  parameter int HOLD     = 16
) (
  input  logic                                                  clkin,
  input  logic                                                  rst_n,
  input  logic                                                  pll_locked,
  input  logic                                                  wr,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]    wr_ch,
  input  logic [ACC_W-1:0]                                      wr_inc,
  input  logic                                                  sync,
  output logic [CHANNELS-1:0]                                   ce,
  output logic [CHANNELS-1:0]                                   tgl,
  output logic                                                  rst_out,
  output logic                                                  ready
);

  localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic               lk_meta_r;
  logic               lk_r;
  logic               run_stay_s;

  logic [ACC_W-1:0]   acc_r [CHANNELS];
  logic [ACC_W-1:0]   inc_r [CHANNELS];
  logic [ACC_W:0]     sum_s [CHANNELS];

  // Two-flop synchronizer for the asynchronous PLL lock flag
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta_r <= 1'b0;
      lk_r      <= 1'b0;
    end else begin
      lk_meta_r <= pll_locked;
      lk_r      <= lk_meta_r;
    end
  end

  // Lock sequencer state and hold counter registers
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_WAIT;
      cnt_r   <= CNT_W'(0);
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Lock sequencer next-state logic; any loss of lock restarts from WAIT
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_WAIT: begin
        if (lk_r) begin
          state_nxt_s = ST_HOLD;
          cnt_nxt_s   = CNT_W'(0);
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (!lk_r) begin
          state_nxt_s = ST_WAIT;
        end else if (cnt_r == CNT_W'(HOLD - 1)) begin
          state_nxt_s = ST_RUN;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lk_r) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_WAIT;
      end
    endcase
  end

  // Accumulate only on edges that start and end in RUN, so the exit edge already clears outputs
  assign run_stay_s = (state_r == ST_RUN) && (state_nxt_s == ST_RUN);

  assign rst_out = (state_r != ST_RUN);
  assign ready   = (state_r == ST_RUN);

  // Per-channel phase sum with carry in the MSB
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      sum_s[i] = {1'b0, acc_r[i]} + {1'b0, inc_r[i]};
    end
  end

  // Increment registers and phase accumulators; acc is never touched by a write
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      ce  <= {CHANNELS{1'b0}};
      tgl <= {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
        acc_r[i] <= ACC_W'(0);
        inc_r[i] <= ACC_W'(0);
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr && (32'(wr_ch) == 32'(i))) begin
          inc_r[i] <= wr_inc;
        end
        if (sync || !run_stay_s) begin
          acc_r[i] <= ACC_W'(0);
          ce[i]    <= 1'b0;
          tgl[i]   <= 1'b0;
        end else begin
          acc_r[i] <= sum_s[i][ACC_W-1:0];
          ce[i]    <= sum_s[i][ACC_W];
          tgl[i]   <= tgl[i] ^ sum_s[i][ACC_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_de0clkgen.sv
// Testbench for de0clkgen: directed lock/rate/sync scenarios, a rate table and
// randomized traffic compared every cycle against a count-based reference model.
module tb_de0clkgen;

  localparam int CH  = 3;
  localparam int AW  = 16;
  localparam int HD  = 16;
  localparam int MOD = 65536;

  logic          clkin = 1'b0;
  logic          rst_n;
  logic          pll_locked;
  logic          wr;
  logic [1:0]    wr_ch;
  logic [15:0]   wr_inc;
  logic          sync;
  logic [CH-1:0] ce;
  logic [CH-1:0] tgl;
  logic          rst_out;
  logic          ready;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  de0clkgen #(.CHANNELS(CH), .ACC_W(AW), .HOLD(HD)) dut (
    .clkin(clkin), .rst_n(rst_n), .pll_locked(pll_locked), .wr(wr), .wr_ch(wr_ch),
    .wr_inc(wr_inc), .sync(sync), .ce(ce), .tgl(tgl), .rst_out(rst_out), .ready(ready)
  );

  always #5 clkin = ~clkin;

  // Reference model: RUN holds once lk has been seen high on HD+1 consecutive edges
  bit            h0, h1;
  int            mc;
  int            m_acc [CH];
  int            m_inc [CH];
  logic [CH-1:0] m_ce, m_tgl;
  bit            m_run;

  always @(posedge clkin or negedge rst_n) begin : model
    bit lkv, was, stay;
    int s;
    if (!rst_n) begin
      h0 = 1'b0; h1 = 1'b0; mc = 0; m_run = 1'b0;
      m_ce = '0; m_tgl = '0;
      for (int i = 0; i < CH; i++) begin m_acc[i] = 0; m_inc[i] = 0; end
    end else begin
      lkv = h1; h1 = h0; h0 = pll_locked;
      was = (mc >= HD + 1);
      mc = lkv ? ((mc < HD + 2) ? mc + 1 : mc) : 0;
      stay = was && (mc >= HD + 1);
      for (int i = 0; i < CH; i++) begin
        if (sync || !stay) begin
          m_acc[i] = 0; m_ce[i] = 1'b0; m_tgl[i] = 1'b0;
        end else begin
          s = m_acc[i] + m_inc[i];
          m_ce[i] = (s >= MOD);
          m_acc[i] = s % MOD;
          if (m_ce[i]) m_tgl[i] = ~m_tgl[i];
        end
      end
      if (wr && (int'(wr_ch) < CH)) m_inc[wr_ch] = int'(wr_inc);
      m_run = (mc >= HD + 1);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clkin) begin
    if (chk_en) begin
      total++;
      if (ce !== m_ce || tgl !== m_tgl || rst_out !== !m_run || ready !== m_run) begin
        bad++;
        $display("FAIL model t=%0t got ce=%b tgl=%b rst_out=%b ready=%b expected ce=%b tgl=%b rst_out=%b ready=%b",
                 $time, ce, tgl, rst_out, ready, m_ce, m_tgl, !m_run, m_run);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clkin);
    @(negedge clkin);
  endtask

  task automatic wr_one(input logic [1:0] ch, input logic [15:0] v);
    wr = 1'b1; wr_ch = ch; wr_inc = v;
    step();
    wr = 1'b0;
  endtask

  typedef struct {
    int i0, i1, i2;
    int n;
    int e0, e1, e2;
  } rate_vec_t;

  rate_vec_t rv [4];

  initial begin : main
    int ce1_cnt;
    int c0, c1, c2;
    int drop_left;

    rv[0] = '{32'h4000, 32'h5556, 32'h0000, 3000, 750, 1000, 0};
    rv[1] = '{32'h8000, 32'h0001, 32'hFFFF, 1000, 500, 0, 999};
    rv[2] = '{32'h1000, 32'h2000, 32'h0000, 256, 16, 32, 0};
    rv[3] = '{32'h0000, 32'hC000, 32'h0100, 512, 0, 384, 2};

    rst_n = 1'b1; pll_locked = 1'b0; wr = 1'b0; wr_ch = 2'd0; wr_inc = 16'h0000; sync = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_rst_out", int'(rst_out), 1);
    chk("reset_ready", int'(ready), 0);
    chk("reset_ce", int'(ce), 0);
    chk("reset_tgl", int'(tgl), 0);
    @(negedge clkin);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // configure before lock, then lock sequence and rates
    wr_one(2'd0, 16'h4000);
    wr_one(2'd1, 16'h5556);
    wr_one(2'd2, 16'h0000);
    pll_locked = 1'b1;
    ce1_cnt = 0;
    for (int e = 1; e <= 3019; e++) begin
      step();
      if (e <= 25) begin
        chk("lock_rst_out", int'(rst_out), int'(e < 19));
        chk("lock_ready", int'(ready), int'(e >= 19));
      end
      if (e >= 20 && e <= 40) begin
        chk("rate_ce0", int'(ce[0]), int'(((e - 19) % 4) == 0));
        chk("rate_tgl0", int'(tgl[0]), ((e - 19) / 4) % 2);
      end
      if (e >= 20 && ce[1]) ce1_cnt++;
    end
    total++;
    if (ce1_cnt < 999 || ce1_cnt > 1001) begin
      bad++;
      $display("FAIL rate_ce1 got %0d pulses expected 1000 (+-1)", ce1_cnt);
    end

    // lock loss in RUN
    pll_locked = 1'b0;
    step();
    chk("loss_k_rst", int'(rst_out), 0);
    step();
    chk("loss_k1_rst", int'(rst_out), 0);
    step();
    chk("loss_k2_rst", int'(rst_out), 1);
    chk("loss_k2_ce", int'(ce), 0);
    chk("loss_k2_tgl", int'(tgl), 0);
    for (int i = 0; i < 3; i++) step();

    // relock with a 3-cycle glitch at hold count 10
    for (int r = 1; r <= 45; r++) begin
      pll_locked = (r >= 12 && r <= 14) ? 1'b0 : 1'b1;
      step();
      chk("glitch_rst_out", int'(rst_out), int'(r < 33));
      if (r >= 34) chk("relock_ce0", int'(ce[0]), int'(((r - 33) % 4) == 0));
    end

    // sync together with a rate write, then an out-of-range write
    sync = 1'b1; wr = 1'b1; wr_ch = 2'd0; wr_inc = 16'h8000;
    step();
    sync = 1'b0; wr = 1'b0;
    chk("sync_tgl", int'(tgl), 0);
    chk("sync_ce", int'(ce), 0);
    for (int n = 1; n <= 16; n++) begin
      if (n == 9) begin wr = 1'b1; wr_ch = 2'd3; wr_inc = 16'hFFFF; end
      step();
      wr = 1'b0;
      chk("sync_ce0", int'(ce[0]), int'((n % 2) == 0));
      if (n >= 10) chk("badch_ce2", int'(ce[2]), 0);
    end

    // rate table: counts over n edges after a sync
    for (int k = 0; k < 4; k++) begin
      wr_one(2'd0, 16'(rv[k].i0));
      wr_one(2'd1, 16'(rv[k].i1));
      wr_one(2'd2, 16'(rv[k].i2));
      sync = 1'b1;
      step();
      sync = 1'b0;
      c0 = 0; c1 = 0; c2 = 0;
      for (int n = 0; n < rv[k].n; n++) begin
        step();
        if (ce[0]) c0++;
        if (ce[1]) c1++;
        if (ce[2]) c2++;
      end
      chk("table_ce0", c0, rv[k].e0);
      chk("table_ce1", c1, rv[k].e1);
      chk("table_ce2", c2, rv[k].e2);
    end

    // randomized traffic checked by the model
    drop_left = 0;
    for (int i = 0; i < 3000; i++) begin
      wr = ($urandom_range(7) == 0);
      wr_ch = 2'($urandom_range(3));
      wr_inc = 16'($urandom);
      sync = ($urandom_range(63) == 0);
      if (drop_left > 0) begin
        pll_locked = 1'b0;
        drop_left--;
      end else begin
        pll_locked = 1'b1;
        if ($urandom_range(299) == 0) drop_left = int'($urandom_range(5, 1));
      end
      step();
    end
    wr = 1'b0; sync = 1'b0; pll_locked = 1'b1;

    // asynchronous reset in the middle of RUN
    wr_one(2'd0, 16'h4000);
    wr_one(2'd1, 16'h5556);
    for (int i = 0; i < 40; i++) step();
    @(posedge clkin);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rst_out", int'(rst_out), 1);
    chk("arst_ready", int'(ready), 0);
    chk("arst_ce", int'(ce), 0);
    chk("arst_tgl", int'(tgl), 0);
    @(negedge clkin);
    rst_n = 1'b1;
    c0 = 0;
    for (int e = 1; e <= 70; e++) begin
      step();
      if (e <= 20) chk("arst_relock_rst", int'(rst_out), int'(e < 19));
      if (ce != '0) c0++;
    end
    chk("arst_inc_cleared", c0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/de0clkgen.md
# de0clkgen

Multi-channel fractional clock-enable generator with PLL-lock reset sequencing. It sits directly behind the board PLL wrapper and takes one PLL output as its single clock plus the PLL `locked` flag. It produces CHANNELS independent clock-enable pulse trains and square-wave toggles at programmable fractional rates. It also produces a clean synchronous reset for downstream logic, released only after lock has been stable.

## Interface
- CHANNELS, 2, number of output channels (1..16)
- ACC_W, 16, phase-accumulator and increment width in bits
- HOLD, 16, number of consecutive locked cycles required before release (1..65535)
- clkin  in  1  sole clock (PLL output)
- rst_n  in  1  reset, asynchronous assert, active-low
- pll_locked  in  1  PLL lock flag, asynchronous to clkin
- wr  in  1  increment-register write strobe
- wr_ch  in  max(1,$clog2(CHANNELS))  target channel for wr
- wr_inc  in  ACC_W  increment value for wr
- sync  in  1  phase-align: clear all accumulators and toggles
- ce  out  CHANNELS  one-cycle enable pulse per channel
- tgl  out  CHANNELS  per-channel square wave, toggles on each ce
- rst_out  out  1  active-high synchronous reset for downstream logic
- ready  out  1  high in RUN state (always the complement of rst_out)

## Operation
- Reset (rst_n=0): state=WAIT_LOCK, synchronizer flops=0, hold counter=0, all acc=0, all inc=0, ce=0, tgl=0, rst_out=1, ready=0.
- pll_locked passes through a 2-flop synchronizer; `lk` denotes its output.
- State machine (one-hot or encoded, implementer's choice). Only lk affects state transitions.
  - WAIT_LOCK: when lk=1 -> HOLD, and the counter is cleared.
  - HOLD: when lk=0 -> WAIT_LOCK. Otherwise the counter increments, and on reaching HOLD-1 the state goes to RUN.
  - RUN: when lk=0 -> WAIT_LOCK.
- rst_out=(state!=RUN) and ready=(state==RUN). Both are decoded from the state register with no extra flop.
- Channel i, while state==RUN: each edge computes {carry,acc[i]} = acc[i] + inc[i], which is ACC_W+1 bits with the carry as the MSB. ce[i] <= carry, and tgl[i] flips when carry=1.
- Mean rate of channel i is f_clk·inc[i]/2^ACC_W. inc=0 means the channel is silent.
- Outside RUN: acc, ce and tgl are held at 0.
- sync=1: on the next edge every acc is cleared, every ce=0 and every tgl=0 in any state, and sync takes priority over accumulation.
- wr=1: inc[wr_ch] <= wr_inc on the next edge. The new value is used from the following edge.
  - Writes are accepted in every state, so channels can be configured before lock.
  - wr_ch >= CHANNELS is ignored.
  - wr and sync in the same cycle both take effect.
- The acc register is never reloaded by wr, so a rate change is glitch-free and phase-continuous.

## Timing
- Edge 1 is the first edge that samples pll_locked=1.
  - Edge 3: the state enters HOLD.
  - Edge HOLD+3: the state enters RUN, and rst_out falls and ready rises after that edge.
  - A lk drop at any HOLD count restarts the whole sequence.
- Loss of lock: the drop is sampled at edge k, and the state leaves RUN at edge k+2. From edge k+2 onwards rst_out=1 and ce/tgl/acc are 0.
- ce latency: RUN edge n is the n-th edge with state==RUN already true. A carry produced at RUN edge n shows as ce high for exactly one cycle after edge n.
- rst_n asserted mid-RUN: all outputs return to their reset values immediately (asynchronously). After rst_n deasserts, the full lock sequence repeats.
- ce is registered, with no combinational path from any input to ce or tgl. rst_out/ready come from state-register decode only.

## Test plan
- Lock sequence, HOLD=16: rst_n released, pll_locked raised at edge 1 and held -> rst_out=1 through edge 18, and rst_out=0/ready=1 after edge 19.
- Lock glitch: pll_locked low for 3 cycles during HOLD count 10 -> state returns to WAIT_LOCK, and the release occurs HOLD+3 edges after the relock sample.
- Rate, ACC_W=16: inc0=0x4000 and inc1=0x5556, written before lock.
  - Ch0: first ce after RUN edge 4, then every 4 cycles, and tgl0 has a period of 8.
  - Ch1: exactly 1000 ce pulses in 3000 RUN cycles (±1).
- Lock loss in RUN: pll_locked dropped -> rst_out=1 and ce=0 from the second edge after sampling. Every acc reads 0 after relock, with the first ce0 again after RUN edge 4.
- sync and wr in the same cycle during RUN, with ch0 at inc=0x4000: sync with wr ch0=0x8000 -> tgl=0 and acc=0, then ce0 every 2 cycles starting after RUN edge 2 following the sync. A write with wr_ch=CHANNELS leaves all inc unchanged.
- Async reset mid-RUN: rst_n pulsed low between edges -> rst_out=1, ce=0, tgl=0 and inc=0 immediately, without waiting for a clock edge.
